// File: rtl/uart_tx_fifo_serializer_pkg.sv
// Shared definitions for the UART transmit path: FIFO geometry, serializer states and
// character-length encodings.
package uart_tx_fifo_serializer_pkg;

  localparam int UTX_FIFO_PTR_W = 4;
  localparam int UTX_FIFO_DEPTH = 1 << UTX_FIFO_PTR_W;
  localparam int UTX_DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

  localparam logic [1:0] CHAR_LEN_5 = 2'b00;
  localparam logic [1:0] CHAR_LEN_6 = 2'b01;
  localparam logic [1:0] CHAR_LEN_7 = 2'b10;
  localparam logic [1:0] CHAR_LEN_8 = 2'b11;

  // Selects the data bits that actually go on the line, so parity ignores the unsent ones.
  function automatic logic [UTX_DATA_W-1:0] char_mask(input logic [1:0] char_len);
    case (char_len)
      CHAR_LEN_5: return 8'h1F;
      CHAR_LEN_6: return 8'h3F;
      CHAR_LEN_7: return 8'h7F;
      CHAR_LEN_8: return 8'hFF;
      default:    return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_serializer_raminfr.sv
// Dual-port RAM backing the transmit FIFO: synchronous write port, asynchronous read port.
module uart_tx_fifo_serializer_raminfr
  import uart_tx_fifo_serializer_pkg::*;
#(
  parameter int ADDR_W = UTX_FIFO_PTR_W,
  parameter int DATA_W = UTX_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] dpra,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dpo
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[a] <= di;
  end

  assign dpo = mem_q[dpra];

endmodule

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmit FIFO plus serializer (start, 5-8 data bits LSB first, optional parity, 1-2 stop).
// Define UART_TX_BREAK_EN to let break_i hold the line low.
module uart_tx_fifo_serializer
  import uart_tx_fifo_serializer_pkg::*;
#(
  parameter int FIFO_PTR_W = UTX_FIFO_PTR_W,
  parameter int FIFO_DEPTH = UTX_FIFO_DEPTH,
  parameter int DATA_W     = UTX_DATA_W
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [1:0]            char_len_i,
  input  logic                  parity_en_i,
  input  logic                  parity_even_i,
  input  logic                  two_stop_i,
  input  logic                  break_i,
  output logic                  stx_o,
  output logic                  busy_o,
  output logic                  tx_done_o,
  output logic [FIFO_PTR_W:0]   fifo_count_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  overrun_o
);

  localparam logic [FIFO_PTR_W:0] FULL_COUNT = (FIFO_PTR_W+1)'(FIFO_DEPTH);

  logic [FIFO_PTR_W-1:0] top_q, top_d, bottom_q, bottom_d;
  logic [FIFO_PTR_W:0]   count_q, count_d;
  tx_state_e             state_q, state_d;
  logic [3:0]            tick_q, tick_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [1:0]            char_len_q, char_len_d;
  logic                  parity_en_q, parity_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_done_q, tx_done_d;
  logic                  overrun_q, overrun_d;
  logic                  push_ok, pop, tick_end, line;
  logic [DATA_W-1:0]     ram_dpo, masked;

  uart_tx_fifo_serializer_raminfr #(
    .ADDR_W (FIFO_PTR_W),
    .DATA_W (DATA_W)
  ) u_raminfr (
    .clk  (clk),
    .we   (push_ok),
    .a    (top_q),
    .dpra (bottom_q),
    .di   (data_i),
    .dpo  (ram_dpo)
  );

  assign fifo_count_o = count_q;
  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == FULL_COUNT);
  assign busy_o       = (state_q != ST_IDLE);
  assign tx_done_o    = tx_done_q;
  assign overrun_o    = overrun_q;

  // Clear wins over push and also suppresses a same-cycle pop.
  always_comb begin
    push_ok   = push_i && !fifo_full_o;
    pop       = (state_q == ST_IDLE) && enable_i && !fifo_empty_o && !clear_i;
    top_d     = top_q;
    bottom_d  = bottom_q;
    count_d   = count_q;
    overrun_d = push_i && fifo_full_o;
    if (clear_i) begin
      top_d    = '0;
      bottom_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) top_d = top_q + 1'b1;
      if (pop) bottom_d = bottom_q + 1'b1;
      if (push_ok && !pop) count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    char_len_d  = char_len_q;
    parity_en_d = parity_en_q;
    two_stop_d  = two_stop_q;
    tx_done_d   = 1'b0;
    masked      = ram_dpo & DATA_W'(char_mask(char_len_i));
    tick_end    = enable_i && (tick_q == 4'd15);
    if (enable_i && state_q != ST_IDLE) tick_d = tick_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d     = ram_dpo;
          char_len_d  = char_len_i;
          parity_en_d = parity_en_i;
          two_stop_d  = two_stop_i;
          parity_d    = parity_even_i ? ^masked : ~^masked;
          bit_d       = '0;
          tick_d      = '0;
          state_d     = ST_START;
        end
      end
      ST_START: if (tick_end) state_d = ST_DATA;
      ST_DATA: begin
        if (tick_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          // Last data bit index is char_len + 4, i.e. 4..7.
          if (bit_q == {1'b1, char_len_q}) begin
            bit_d   = '0;
            state_d = parity_en_q ? ST_PARITY : ST_STOP1;
          end
        end
      end
      ST_PARITY: if (tick_end) state_d = ST_STOP1;
      ST_STOP1: begin
        if (tick_end) begin
          if (two_stop_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d   = ST_IDLE;
            tx_done_d = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (tick_end) begin
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line = 1'b1;
    unique case (state_q)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shift_q[0];
      ST_PARITY: line = parity_q;
      default:   line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      top_q       <= '0;
      bottom_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      char_len_q  <= '0;
      parity_en_q <= 1'b0;
      two_stop_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      char_len_q  <= char_len_d;
      parity_en_q <= parity_en_d;
      two_stop_q  <= two_stop_d;
      tx_done_q   <= tx_done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_TX_BREAK_EN
  // Break only masks the pin; the serializer keeps running underneath.
  logic break_q, break_d;
  assign break_d = break_i;
  always_ff @(posedge clk) begin
    if (wb_rst_i) break_q <= 1'b0;
    else          break_q <= break_d;
  end
  assign stx_o = line & ~break_q;
`else
  logic unused_break;
  assign unused_break = break_i;
  assign stx_o        = line;
`endif

endmodule
